// File: rtl/ppu_pkg.sv
// ppu_pkg: constants shared by the PPU register port and its VRAM access unit.
//   REG_*      CPU register indices ($2000-$2007, low three address bits)
//   INC_*      PPUDATA address step (across a row / down a column)
//   PAL_BASE   first palette address; PPUDATA reads from here on bypass the buffer
//   VADDR_W    VRAM address width
package ppu_pkg;

  localparam int VADDR_W = 14;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  localparam logic [13:0] INC_ACROSS = 14'd1;
  localparam logic [13:0] INC_DOWN   = 14'd32;

  typedef enum logic {
    VS_IDLE     = 1'b0,
    VS_WAIT_ACK = 1'b1
  } vram_state_e;

endpackage

// File: rtl/ppu_vram_access.sv
// ppu_vram_access: single-outstanding VRAM req/ack engine.
//   clk, reset        clock, synchronous active-high reset
//   start, start_*    launch an access (honoured only when idle)
//   busy              access outstanding (WAIT_ACK)
//   done              ack accepted this cycle
//   vramReq..vramAck  VRAM port; address/data/we held stable while vramReq
// A reset drops vramReq immediately; an ack seen while idle is ignored.
module ppu_vram_access
  import ppu_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          start_we,
  input  logic [AW-1:0] start_addr,
  input  logic [7:0]    start_wdata,
  output logic          busy,
  output logic          done,
  output logic          vramReq,
  output logic          vramWe,
  output logic [AW-1:0] vramAddr,
  output logic [7:0]    vramWData,
  input  logic          vramAck
);

  vram_state_e   state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      VS_IDLE: begin
        if (start) begin
          state_d = VS_WAIT_ACK;
          we_d    = start_we;
          addr_d  = start_addr;
          wdata_d = start_wdata;
        end
      end
      VS_WAIT_ACK: begin
        if (vramAck) state_d = VS_IDLE;
      end
      default: state_d = VS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= VS_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = (state_q == VS_WAIT_ACK);
  assign done      = busy & vramAck;
  assign vramReq   = busy;
  assign vramWe    = we_q;
  assign vramAddr  = addr_q;
  assign vramWData = wdata_q;

endmodule

// File: rtl/ppu_reg_port.sv
// ppu_reg_port: CPU-facing responder for the eight PPU registers.
//   clk, reset              clock, synchronous active-high reset
//   cpuReq/We/Addr/WData    one-cycle register access, taken when cpuReady=1
//   cpuRData, cpuReady      registered read data; 0 while a PPUDATA access stalls
//   nmi                     ppuCtrl[7] & vblank, registered
//   ppuCtrl..oamAddr        architectural register values
//   oamWe/oamWData/oamRData OAM port (strobe applies to current oamAddr)
//   vram*                   VRAM req/ack port
//   vblankSet/Clr, spr0HitIn, sprOvfIn  status pulses from PPU timing
module ppu_reg_port #(
  parameter int                 VADDR_W  = ppu_pkg::VADDR_W,
  parameter logic [VADDR_W-1:0] PAL_BASE = ppu_pkg::PAL_BASE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpuReq,
  input  logic               cpuWe,
  input  logic [2:0]         cpuAddr,
  input  logic [7:0]         cpuWData,
  output logic [7:0]         cpuRData,
  output logic               cpuReady,
  output logic               nmi,
  output logic [7:0]         ppuCtrl,
  output logic [7:0]         ppuMask,
  output logic [7:0]         scrollX,
  output logic [7:0]         scrollY,
  output logic [7:0]         oamAddr,
  output logic               oamWe,
  output logic [7:0]         oamWData,
  input  logic [7:0]         oamRData,
  output logic               vramReq,
  output logic               vramWe,
  output logic [VADDR_W-1:0] vramAddr,
  output logic [7:0]         vramWData,
  input  logic [7:0]         vramRData,
  input  logic               vramAck,
  input  logic               vblankSet,
  input  logic               vblankClr,
  input  logic               spr0HitIn,
  input  logic               sprOvfIn
);

  import ppu_pkg::*;

  logic [7:0]         ppu_ctrl_q, ppu_ctrl_d;
  logic [7:0]         ppu_mask_q, ppu_mask_d;
  logic [7:0]         scroll_x_q, scroll_x_d;
  logic [7:0]         scroll_y_q, scroll_y_d;
  logic [7:0]         oam_addr_q, oam_addr_d;
  logic               oam_we_q, oam_we_d;
  logic [7:0]         oam_wdata_q, oam_wdata_d;
  logic [VADDR_W-1:0] v_q, v_d;
  logic               toggle_q, toggle_d;
  logic               vblank_q, vblank_d;
  logic               spr0_q, spr0_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         read_buf_q, read_buf_d;
  logic [7:0]         open_bus_q, open_bus_d;
  logic [7:0]         cpu_rdata_q, cpu_rdata_d;
  logic               nmi_q, nmi_d;
  logic               pal_pend_q, pal_pend_d;  // palette read issued, CPU stalled

  logic               cpu_ready, acc, is_data, v_pal;
  logic               vram_start, vram_busy, vram_done;
  logic [VADDR_W-1:0] inc;
  logic [7:0]         rd;

  assign is_data = (cpuAddr == REG_DATA);
  assign v_pal   = (v_q >= PAL_BASE);
  assign inc     = ppu_ctrl_q[2] ? VADDR_W'(INC_DOWN) : VADDR_W'(INC_ACROSS);

  // A palette read is issued while stalled and completes on the ack cycle.
  // Any other PPUDATA access waits until the engine is idle again.
  always_comb begin
    cpu_ready = 1'b1;
    if (pal_pend_q)
      cpu_ready = vram_done;
    else if (cpuReq && is_data)
      cpu_ready = !vram_busy && (cpuWe || !v_pal);
  end

  assign acc        = cpuReq & cpu_ready;
  // Covers accepted writes, buffered reads and the stalled palette issue.
  assign vram_start = cpuReq & is_data & ~vram_busy;

  always_comb begin
    ppu_ctrl_d  = ppu_ctrl_q;
    ppu_mask_d  = ppu_mask_q;
    scroll_x_d  = scroll_x_q;
    scroll_y_d  = scroll_y_q;
    oam_addr_d  = oam_addr_q;
    oam_we_d    = 1'b0;
    oam_wdata_d = oam_wdata_q;
    v_d         = v_q;
    toggle_d    = toggle_q;
    vblank_d    = vblank_q;
    spr0_d      = spr0_q;
    ovf_d       = ovf_q;
    read_buf_d  = read_buf_q;
    open_bus_d  = open_bus_q;
    cpu_rdata_d = cpu_rdata_q;
    pal_pend_d  = pal_pend_q;
    rd          = open_bus_q;

    // OAM strobe is registered, so the pointer steps after the write lands.
    if (oam_we_q) oam_addr_d = oam_addr_q + 8'd1;

    if (vblankSet) vblank_d = 1'b1;
    if (spr0HitIn) spr0_d   = 1'b1;
    if (sprOvfIn)  ovf_d    = 1'b1;
    if (vblankClr) begin
      vblank_d = 1'b0;
      spr0_d   = 1'b0;
      ovf_d    = 1'b0;
    end

    if (vram_done) begin
      pal_pend_d = 1'b0;
      if (!vramWe) read_buf_d = vramRData;
    end

    if (vram_start) begin
      v_d = v_q + inc;
      if (!cpuWe && v_pal) pal_pend_d = 1'b1;
    end

    if (acc) begin
      if (cpuWe) begin
        open_bus_d = cpuWData;
        case (cpuAddr)
          REG_CTRL:    ppu_ctrl_d = cpuWData;
          REG_MASK:    ppu_mask_d = cpuWData;
          REG_OAMADDR: oam_addr_d = cpuWData;
          REG_OAMDATA: begin
            oam_we_d    = 1'b1;
            oam_wdata_d = cpuWData;
          end
          REG_SCROLL: begin
            if (!toggle_q) scroll_x_d = cpuWData;
            else           scroll_y_d = cpuWData;
            toggle_d = ~toggle_q;
          end
          REG_ADDR: begin
            if (!toggle_q) v_d = {cpuWData[VADDR_W-9:0], v_q[7:0]};
            else           v_d = {v_q[VADDR_W-1:8], cpuWData};
            toggle_d = ~toggle_q;
          end
          default: ;
        endcase
      end else begin
        case (cpuAddr)
          REG_STATUS: begin
            // A read racing vblankSet sees 0 and keeps vblank low.
            rd       = {vblank_q & ~vblankSet, spr0_q, ovf_q, open_bus_q[4:0]};
            vblank_d = 1'b0;
            toggle_d = 1'b0;
          end
          REG_OAMDATA: rd = oamRData;
          REG_DATA:    rd = pal_pend_q ? vramRData : read_buf_q;
          default:     rd = open_bus_q;
        endcase
        cpu_rdata_d = rd;
        open_bus_d  = rd;
      end
    end

    nmi_d = ppu_ctrl_d[7] & vblank_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ppu_ctrl_q  <= '0;
      ppu_mask_q  <= '0;
      scroll_x_q  <= '0;
      scroll_y_q  <= '0;
      oam_addr_q  <= '0;
      oam_we_q    <= 1'b0;
      oam_wdata_q <= '0;
      v_q         <= '0;
      toggle_q    <= 1'b0;
      vblank_q    <= 1'b0;
      spr0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      read_buf_q  <= '0;
      open_bus_q  <= '0;
      cpu_rdata_q <= '0;
      nmi_q       <= 1'b0;
      pal_pend_q  <= 1'b0;
    end else begin
      ppu_ctrl_q  <= ppu_ctrl_d;
      ppu_mask_q  <= ppu_mask_d;
      scroll_x_q  <= scroll_x_d;
      scroll_y_q  <= scroll_y_d;
      oam_addr_q  <= oam_addr_d;
      oam_we_q    <= oam_we_d;
      oam_wdata_q <= oam_wdata_d;
      v_q         <= v_d;
      toggle_q    <= toggle_d;
      vblank_q    <= vblank_d;
      spr0_q      <= spr0_d;
      ovf_q       <= ovf_d;
      read_buf_q  <= read_buf_d;
      open_bus_q  <= open_bus_d;
      cpu_rdata_q <= cpu_rdata_d;
      nmi_q       <= nmi_d;
      pal_pend_q  <= pal_pend_d;
    end
  end

  ppu_vram_access #(.AW(VADDR_W)) u_vram (
    .clk        (clk),
    .reset      (reset),
    .start      (vram_start),
    .start_we   (cpuWe),
    .start_addr (v_q),
    .start_wdata(cpuWData),
    .busy       (vram_busy),
    .done       (vram_done),
    .vramReq    (vramReq),
    .vramWe     (vramWe),
    .vramAddr   (vramAddr),
    .vramWData  (vramWData),
    .vramAck    (vramAck)
  );

  assign cpuReady = cpu_ready;
  assign cpuRData = cpu_rdata_q;
  assign nmi      = nmi_q;
  assign ppuCtrl  = ppu_ctrl_q;
  assign ppuMask  = ppu_mask_q;
  assign scrollX  = scroll_x_q;
  assign scrollY  = scroll_y_q;
  assign oamAddr  = oam_addr_q;
  assign oamWe    = oam_we_q;
  assign oamWData = oam_wdata_q;

endmodule

// File: tb/tb_ppu_reg_port.sv
`timescale 1ns/1ps
module tb_ppu_reg_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpuReq = 1'b0, cpuWe = 1'b0;
  logic [2:0]  cpuAddr = '0;
  logic [7:0]  cpuWData = '0;
  logic [7:0]  cpuRData;
  logic        cpuReady, nmi;
  logic [7:0]  ppuCtrl, ppuMask, scrollX, scrollY, oamAddr, oamWData, oamRData;
  logic        oamWe, vramReq, vramWe;
  logic [13:0] vramAddr;
  logic [7:0]  vramWData;
  logic [7:0]  vramRData = '0;
  logic        vramAck = 1'b0;
  logic        vblankSet = 1'b0, vblankClr = 1'b0, spr0HitIn = 1'b0, sprOvfIn = 1'b0;

  always #5 clk = ~clk;

  // OAM stand-in: data is a fixed function of the pointer
  assign oamRData = oamAddr ^ 8'h5C;

  ppu_reg_port dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuRData(cpuRData), .cpuReady(cpuReady), .nmi(nmi),
    .ppuCtrl(ppuCtrl), .ppuMask(ppuMask), .scrollX(scrollX), .scrollY(scrollY),
    .oamAddr(oamAddr), .oamWe(oamWe), .oamWData(oamWData), .oamRData(oamRData),
    .vramReq(vramReq), .vramWe(vramWe), .vramAddr(vramAddr), .vramWData(vramWData),
    .vramRData(vramRData), .vramAck(vramAck),
    .vblankSet(vblankSet), .vblankClr(vblankClr), .spr0HitIn(spr0HitIn), .sprOvfIn(sprOvfIn)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  data;
  } vexp_t;

  vexp_t      vq[$];      // expected VRAM requests, in issue order
  logic [7:0] rq[$];      // expected CPU read data
  logic [7:0] mem [0:16383];
  logic [7:0] ob = 8'h00; // open-bus model
  bit         vram_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // VRAM responder: acks each request 3 cycles after it appears and
  // checks it against the scoreboard when first seen.
  initial begin : vram_model
    int    lat;
    bit    seen;
    vexp_t e;
    lat = 0;
    seen = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (vram_en) begin
        vramAck = 1'b0;
        if (!vramReq) seen = 1'b0;
        else begin
          if (!seen) begin
            seen = 1'b1;
            lat = 0;
            if (vq.size() == 0) chk("vram_unexpected_req", vq.size(), 1);
            else begin
              e = vq.pop_front();
              chk("vram_we", vramWe, e.we);
              chk("vram_addr", vramAddr, e.addr);
              if (e.we) chk("vram_wdata", vramWData, e.data);
            end
          end
          lat++;
          if (lat == 3) begin
            vramAck = 1'b1;
            if (vramWe) mem[vramAddr] = vramWData;
            vramRData = mem[vramAddr];
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // All main-sequence tasks start and end at posedge+1.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    #1;
    while (!cpuReady && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_ready"}, cpuReady, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = a; cpuWData = d;
    wait_ready("wr");
    cpuReq = 1'b0; cpuWe = 1'b0;
    ob = d;
  endtask

  task automatic cpu_rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] e;
    rq.push_back(exp);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = a;
    wait_ready(tag);
    cpuReq = 1'b0;
    e = rq.pop_front();
    chk(tag, cpuRData, e);
    ob = e;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((vramReq || vq.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_vramReq", vramReq, 1'b0);
    chk("idle_queue", vq.size(), 0);
  endtask

  task automatic push_v(input logic we, input logic [13:0] a, input logic [7:0] d);
    vexp_t e;
    e.we = we; e.addr = a; e.data = d;
    vq.push_back(e);
  endtask

  initial begin : main
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2000] = 8'h11;
    mem[14'h2001] = 8'h22;
    mem[14'h3F00] = 8'h2C;

    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_ready", cpuReady, 1'b1);
    chk("rst_vramReq", vramReq, 1'b0);
    chk("rst_nmi", nmi, 1'b0);
    chk("rst_oamWe", oamWe, 1'b0);
    chk("rst_ctrl", ppuCtrl, 8'h00);
    chk("rst_rdata", cpuRData, 8'h00);

    cpu_rd("status_after_reset", 3'd2, 8'h00);
    cpu_wr(3'd0, 8'hA5);
    chk("ctrl_a5", ppuCtrl, 8'hA5);
    cpu_rd("openbus_reg0", 3'd0, 8'hA5);

    // increment 32
    cpu_wr(3'd0, 8'h04);
    cpu_wr(3'd6, 8'h21); cpu_wr(3'd6, 8'h08);
    push_v(1'b1, 14'h2108, 8'h11); cpu_wr(3'd7, 8'h11);
    push_v(1'b1, 14'h2128, 8'h22); cpu_wr(3'd7, 8'h22);
    // increment 1
    cpu_wr(3'd0, 8'h00);
    cpu_wr(3'd6, 8'h21); cpu_wr(3'd6, 8'h08);
    push_v(1'b1, 14'h2108, 8'h5A); cpu_wr(3'd7, 8'h5A);
    push_v(1'b1, 14'h2109, 8'h6B); cpu_wr(3'd7, 8'h6B);
    wait_idle();
    chk("mem_2108", mem[14'h2108], 8'h5A);

    // buffered reads, then a palette read
    cpu_wr(3'd6, 8'h20); cpu_wr(3'd6, 8'h00);
    push_v(1'b0, 14'h2000, 8'h00); cpu_rd("rd_buf_first", 3'd7, 8'h00);
    push_v(1'b0, 14'h2001, 8'h00); cpu_rd("rd_buf_second", 3'd7, 8'h11);
    cpu_wr(3'd6, 8'h3F); cpu_wr(3'd6, 8'h00);
    push_v(1'b0, 14'h3F00, 8'h00); cpu_rd("rd_pal", 3'd7, 8'h2C);
    cpu_wr(3'd6, 8'h20); cpu_wr(3'd6, 8'h00);
    push_v(1'b0, 14'h2000, 8'h00); cpu_rd("rd_buf_after_pal", 3'd7, 8'h2C);
    wait_idle();

    // NMI from vblankSet with ctrl[7]=1
    cpu_wr(3'd0, 8'h80);
    vblankSet = 1'b1; tick(); vblankSet = 1'b0;
    chk("nmi_on_vblank", nmi, 1'b1);
    cpu_rd("status_vblank", 3'd2, {3'b100, ob[4:0]});
    chk("nmi_after_status", nmi, 1'b0);

    // NMI raised by ctrl write during vblank
    cpu_wr(3'd0, 8'h00);
    vblankSet = 1'b1; tick(); vblankSet = 1'b0;
    chk("nmi_ctrl0", nmi, 1'b0);
    cpu_wr(3'd0, 8'h80);
    chk("nmi_ctrl_write", nmi, 1'b1);
    cpu_rd("status_vblank2", 3'd2, {3'b100, ob[4:0]});

    // status read racing vblankSet
    vblankSet = 1'b1;
    cpu_rd("status_race", 3'd2, {3'b000, ob[4:0]});
    vblankSet = 1'b0;
    chk("nmi_race", nmi, 1'b0);
    tick();
    chk("nmi_race_later", nmi, 1'b0);
    cpu_rd("status_race_after", 3'd2, {3'b000, ob[4:0]});

    // sprite flags, open-bus low bits, clear-wins
    spr0HitIn = 1'b1; sprOvfIn = 1'b1; tick(); spr0HitIn = 1'b0; sprOvfIn = 1'b0;
    cpu_wr(3'd2, 8'h1F);
    chk("reg2_write_ignored_ctrl", ppuCtrl, 8'h80);
    cpu_rd("status_spr", 3'd2, 8'h7F);
    vblankSet = 1'b1; vblankClr = 1'b1; tick(); vblankSet = 1'b0; vblankClr = 1'b0;
    chk("nmi_clr_wins", nmi, 1'b0);
    cpu_rd("status_clr_wins", 3'd2, 8'h1F);

    // toggle reset by status read
    cpu_wr(3'd6, 8'h3F);
    cpu_rd("status_toggle", 3'd2, 8'h1F);
    cpu_wr(3'd6, 8'h3F); cpu_wr(3'd6, 8'h10);
    push_v(1'b1, 14'h3F10, 8'h99); cpu_wr(3'd7, 8'h99);
    wait_idle();

    // OAM pointer wrap and data read
    cpu_wr(3'd3, 8'hFF);
    chk("oam_addr_ff", oamAddr, 8'hFF);
    cpu_wr(3'd4, 8'h77);
    chk("oam_we_pulse", oamWe, 1'b1);
    chk("oam_wdata", oamWData, 8'h77);
    chk("oam_addr_at_write", oamAddr, 8'hFF);
    tick();
    chk("oam_we_drop", oamWe, 1'b0);
    chk("oam_addr_wrap", oamAddr, 8'h00);
    cpu_rd("oam_read", 3'd4, 8'h5C);
    chk("oam_addr_no_inc", oamAddr, 8'h00);

    // scroll and mask
    cpu_wr(3'd5, 8'h12); cpu_wr(3'd5, 8'h34);
    chk("scroll_x", scrollX, 8'h12);
    chk("scroll_y", scrollY, 8'h34);
    cpu_wr(3'd1, 8'h1E);
    chk("mask", ppuMask, 8'h1E);
    cpu_rd("openbus_reg5", 3'd5, 8'h1E);

    // reset during an outstanding access, then a stray ack
    vram_en = 1'b0;
    cpu_wr(3'd7, 8'hAB);
    chk("pre_rst_vramReq", vramReq, 1'b1);
    reset = 1'b1;
    tick();
    chk("rst_mid_vramReq", vramReq, 1'b0);
    chk("rst_mid_ready", cpuReady, 1'b1);
    reset = 1'b0;
    ob = 8'h00;
    vramAck = 1'b1; tick(); vramAck = 1'b0;
    tick();
    chk("late_ack_vramReq", vramReq, 1'b0);
    chk("late_ack_ctrl", ppuCtrl, 8'h00);
    chk("late_ack_oam", oamAddr, 8'h00);
    chk("late_ack_rdata", cpuRData, 8'h00);
    vram_en = 1'b1;
    cpu_rd("status_post_rst", 3'd2, 8'h00);
    push_v(1'b1, 14'h0000, 8'hC3); cpu_wr(3'd7, 8'hC3);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
